exc_request_ctrl: RTL
=====================

// Module: exc_request_ctrl
// PURPOSE
//  Initiator side of the CP0 exception interface in the multicycle MIPS54 core.
//  Detects traps (syscall/break/teq) and external interrupts, and masks them against CP0 status.
//  Raises a held request/ack handshake toward CP0 for exception entry or eret.
//  Stalls the datapath and redirects the PC to the exception vector or to the EPC.
// PARAMETERS
//  N_INT      6             number of external interrupt lines (1..8)
//  EXC_VECTOR 32'h00400004  exception entry PC
// PORTS
//  clk          in   1   single clock, rising edge
//  rst          in   1   asynchronous, active-low reset
//  instr_valid  in   1   decoded instruction in current cycle is committing
//  is_syscall   in   1   decoded syscall
//  is_break     in   1   decoded break
//  teq_hit      in   1   decoded teq with rs==rt
//  is_eret      in   1   decoded eret
//  pc           in   32  PC of committing instruction
//  ext_int      in   N_INT  asynchronous level interrupt lines
//  status       in   32  CP0 status (reg 12)
//  cp0_epc      in   32  CP0 EPC (reg 14)
//  cp0_ack      in   1   CP0 has performed the requested update this cycle
//  exc_req      out  1   exception-entry request to CP0
//  eret_req     out  1   eret request to CP0
//  cause        out  5   ExcCode for CP0 cause[6:2], valid while exc_req=1
//  epc          out  32  PC to save, valid while exc_req=1
//  stall        out  1   freeze fetch/commit while the block is not IDLE
//  pc_redirect  out  1   one-cycle pulse: load redirect_pc into the PC
//  redirect_pc  out  32  target PC, valid with pc_redirect
//  exc_count    out  16  exceptions taken since reset, saturating
// BEHAVIOUR
//  Reset: state=IDLE. All outputs 0. Interrupt pending bits and exc_count are cleared.
//  ExcCodes: INT=5'd0, SYSCALL=5'd8, BREAK=5'd9, TEQ=5'd13.
//  Enable rule: a trap is enabled iff status[0] and its own bit (status[1]/[2]/[3]) are set.
//  Enable rule: interrupt i is enabled iff status[0] and status[8+i] are set.
//  Disabled traps are dropped: no request, no stall.
//  Priority, evaluated in IDLE only: syscall > break > teq > interrupt (lowest i first) > eret.
//  Sync traps and eret are qualified by instr_valid. Interrupts are not.
//  FSM IDLE:
//   - on a taken trap/interrupt: latch cause/epc, go EXC. epc = pc for traps.
//   - epc = pc of next commit for interrupts, taken only when instr_valid=1, before it commits.
//   - on is_eret: go ERET.
//  FSM EXC: exc_req=1, stall=1, cause/epc held stable until cp0_ack. On ack go REDIR_EXC.
//  FSM ERET: eret_req=1, stall=1 until cp0_ack. On ack go REDIR_ERET.
//  FSM REDIR_EXC: pc_redirect=1, redirect_pc=EXC_VECTOR, stall=1. exc_count+1 (sat 16'hFFFF). Go IDLE.
//  FSM REDIR_ERET: pc_redirect=1, redirect_pc=cp0_epc (sampled this cycle), stall=1. Go IDLE.
//  Latency: request asserts the cycle after detection. Redirect is 1 cycle after ack. Minimum 3 cycles in total.
//  exc_req and eret_req are never both 1. Requests never drop before cp0_ack.
//  cp0_ack seen in IDLE or REDIR_* is ignored.
//  Interrupts: each line has a pending bit. It is set while the synchronised line is high.
//  The pending bit of the taken line is cleared on entry to EXC.
//  An interrupt that arrives during non-IDLE states stays pending.
//  Reset asserted mid-handshake: immediate return to IDLE. Requests drop asynchronously.
//  Inputs that are X while instr_valid=0 must not affect state.
// CONFIGURATION
//  EXC_EXT_INT_EN defined:
//   - ext_int passes through 2-flop synchronisers, then into the pending logic above.
//  EXC_EXT_INT_EN undefined:
//   - ext_int is ignored and no pending/sync flops exist.
//   - INT is never raised. All other behaviour is identical.
// STRUCTURE
//  Package exc_pkg:
//   - ExcCode localparams (INT/SYSCALL/BREAK/TEQ).
//   - status bit index constants (IE=0, SYS=1, BRK=2, TEQ=3, IM_BASE=8).
//   - state enum {IDLE, EXC, ERET, REDIR_EXC, REDIR_ERET}.
//   - default EXC_VECTOR.
//  Sub-module int_sync: N_INT-wide 2-flop synchroniser, async active-low reset.
//   - instantiated only under EXC_EXT_INT_EN.
// TESTING
//  1 status=32'h3, syscall, pc=32'h00400100, ack after 2 cycles:
//    -> exc_req held 2 cycles, cause=8, epc=32'h00400100.
//    -> then pc_redirect with redirect_pc=32'h00400004, exc_count=1.
//  2 status=32'h1 (syscall bit off), syscall -> no exc_req, stall=0, exc_count unchanged.
//  3 status=32'hF, syscall and teq_hit in the same cycle -> cause=8 only.
//  4 eret, cp0_epc=32'h00400200, immediate ack -> eret_req 1 cycle, then pc_redirect to 32'h00400200.
//  5 EXC_EXT_INT_EN, status=32'h101, ext_int[0] pulsed high during EXC:
//    -> stays pending, taken after return to IDLE with cause=0.
//  6 rst low while exc_req=1 -> exc_req=0 immediately, state IDLE, exc_count=0.
//  7 exc_count preset near 16'hFFFF, 2 more traps -> saturates at 16'hFFFF.

Source files
------------

// File: rtl/exc_pkg.sv
// Shared constants and types for the CP0 exception request controller.
package exc_pkg;

    // ExcCode values written into CP0 cause[6:2]
    localparam logic [4:0] EXC_INT     = 5'd0;
    localparam logic [4:0] EXC_SYSCALL = 5'd8;
    localparam logic [4:0] EXC_BREAK   = 5'd9;
    localparam logic [4:0] EXC_TEQ     = 5'd13;

    // CP0 status bit positions
    localparam int ST_IE      = 0;
    localparam int ST_SYS     = 1;
    localparam int ST_BRK     = 2;
    localparam int ST_TEQ     = 3;
    localparam int ST_IM_BASE = 8;

    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0040_0004;

    typedef enum logic [2:0] {
        IDLE,
        EXC,
        ERET,
        REDIR_EXC,
        REDIR_ERET
    } exc_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/exc_request_ctrl_int_sync.sv
// Two-flop synchroniser bank for the asynchronous external interrupt lines.
module int_sync #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    // Two register stages per line to resolve metastability
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/exc_request_ctrl.sv
// Initiator side of the CP0 exception interface: detects traps and interrupts,
// holds a request/ack handshake with CP0, stalls the core and redirects the PC.
// Build option: define EXC_EXT_INT_EN to enable the external interrupt path
// (synchronisers + pending bits). Without it ext_int_i is ignored.
//
// state      | meaning
// IDLE       | normal execution, evaluating traps/interrupts/eret
// EXC        | exception-entry request held until cp0_ack
// ERET       | eret request held until cp0_ack
// REDIR_EXC  | one-cycle redirect to the exception vector
// REDIR_ERET | one-cycle redirect to CP0 EPC
module exc_request_ctrl
    import exc_pkg::*;
#(
    parameter int          N_INT      = 6,
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             instr_valid_i,
    input  logic             is_syscall_i,
    input  logic             is_break_i,
    input  logic             teq_hit_i,
    input  logic             is_eret_i,
    input  logic [31:0]      pc_i,
    input  logic [N_INT-1:0] ext_int_i,
    input  logic [31:0]      status_i,
    input  logic [31:0]      cp0_epc_i,
    input  logic             cp0_ack_i,
    output logic             exc_req_o,
    output logic             eret_req_o,
    output logic [4:0]       cause_o,
    output logic [31:0]      epc_o,
    output logic             stall_o,
    output logic             pc_redirect_o,
    output logic [31:0]      redirect_pc_o,
    output logic [15:0]      exc_count_o
);

    exc_state_e       state_q;
    logic             exc_req_q;
    logic             eret_req_q;
    logic             stall_q;
    logic             pc_redirect_q;
    logic [4:0]       cause_q;
    logic [31:0]      epc_q;
    logic [15:0]      exc_count_q;

    logic [N_INT-1:0] pend_q;
    logic [N_INT-1:0] int_mask;
    logic             int_hit;
    logic             idle_commit;
    logic             trap_go;
    logic [4:0]       trap_cause;
    logic             take_int;
    logic             take_eret;

    // Everything decoded is gated by instr_valid first so X decode fields are harmless
    assign idle_commit = (state_q == IDLE) && instr_valid_i;

    // Lowest-numbered enabled pending line wins
    always_comb begin
        int_hit  = 1'b0;
        int_mask = '0;
        for (int i = N_INT - 1; i >= 0; i--) begin
            if (pend_q[i] && status_i[ST_IM_BASE + i]) begin
                int_hit     = 1'b1;
                int_mask    = '0;
                int_mask[i] = 1'b1;
            end
        end
    end

    // Enabled synchronous trap selection, syscall > break > teq
    always_comb begin
        trap_go    = 1'b0;
        trap_cause = EXC_SYSCALL;
        if (idle_commit && status_i[ST_IE]) begin
            if (is_syscall_i && status_i[ST_SYS]) begin
                trap_go    = 1'b1;
                trap_cause = EXC_SYSCALL;
            end else if (is_break_i && status_i[ST_BRK]) begin
                trap_go    = 1'b1;
                trap_cause = EXC_BREAK;
            end else if (teq_hit_i && status_i[ST_TEQ]) begin
                trap_go    = 1'b1;
                trap_cause = EXC_TEQ;
            end
        end
    end

    // Interrupts are taken in front of a committing instruction so its pc becomes EPC
    assign take_int  = idle_commit && status_i[ST_IE] && int_hit && !trap_go;
    assign take_eret = idle_commit && is_eret_i && !trap_go && !take_int;

`ifdef EXC_EXT_INT_EN
    logic [N_INT-1:0] ext_sync;
    logic [N_INT-1:0] pend_d;

    int_sync #(.W(N_INT)) u_int_sync (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .d_i     (ext_int_i),
        .q_o     (ext_sync)
    );

    // Clear the taken line on EXC entry; a line still high re-arms its bit
    always_comb begin
        pend_d = (pend_q & ~(take_int ? int_mask : '0)) | ext_sync;
    end

    // Pending bits survive non-IDLE states until serviced
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end
`else
    logic unused_int;
    assign pend_q     = '0;
    assign unused_int = ^{ext_int_i, int_mask};
`endif

    logic unused_status;
    assign unused_status = ^status_i;

    // Handshake FSM with registered request/stall/redirect outputs
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= IDLE;
            exc_req_q     <= 1'b0;
            eret_req_q    <= 1'b0;
            stall_q       <= 1'b0;
            pc_redirect_q <= 1'b0;
            cause_q       <= '0;
            epc_q         <= '0;
            exc_count_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (trap_go || take_int) begin
                        state_q   <= EXC;
                        exc_req_q <= 1'b1;
                        stall_q   <= 1'b1;
                        cause_q   <= trap_go ? trap_cause : EXC_INT;
                        epc_q     <= pc_i;
                    end else if (take_eret) begin
                        state_q    <= ERET;
                        eret_req_q <= 1'b1;
                        stall_q    <= 1'b1;
                    end
                end
                EXC: begin
                    if (cp0_ack_i) begin
                        state_q       <= REDIR_EXC;
                        exc_req_q     <= 1'b0;
                        pc_redirect_q <= 1'b1;
                        exc_count_q   <= sat_inc16(exc_count_q);
                    end
                end
                ERET: begin
                    if (cp0_ack_i) begin
                        state_q       <= REDIR_ERET;
                        eret_req_q    <= 1'b0;
                        pc_redirect_q <= 1'b1;
                    end
                end
                REDIR_EXC, REDIR_ERET: begin
                    state_q       <= IDLE;
                    pc_redirect_q <= 1'b0;
                    stall_q       <= 1'b0;
                end
                default: begin
                    state_q       <= IDLE;
                    exc_req_q     <= 1'b0;
                    eret_req_q    <= 1'b0;
                    stall_q       <= 1'b0;
                    pc_redirect_q <= 1'b0;
                end
            endcase
        end
    end

    // Eret target follows CP0 EPC as seen during the redirect cycle itself
    always_comb begin
        redirect_pc_o = '0;
        if (state_q == REDIR_EXC) begin
            redirect_pc_o = EXC_VECTOR;
        end else if (state_q == REDIR_ERET) begin
            redirect_pc_o = cp0_epc_i;
        end
    end

    assign exc_req_o     = exc_req_q;
    assign eret_req_o    = eret_req_q;
    assign stall_o       = stall_q;
    assign pc_redirect_o = pc_redirect_q;
    assign cause_o       = cause_q;
    assign epc_o         = epc_q;
    assign exc_count_o   = exc_count_q;

endmodule
